// File: rtl/formato_pkg.sv
// ---------------------------------------------------------------------------
// formato_pkg
// Shared fixed-point helpers for the downscaling datapath.
//   - ROUND_TRUNC / ROUND_NEAREST : rounding modes for the final integer
//     conversion of the bilinear interpolator.
//   - q8_8_t, to_q8_8, lerp, from_q8_8_sat : Q8.8 helpers for the default
//     8-bit / 8-fraction configuration.
//   - sat_unsigned : clamps an unsigned value to a given bit width.
// ---------------------------------------------------------------------------
package formato_pkg;

   localparam int ROUND_TRUNC   = 0;
   localparam int ROUND_NEAREST = 1;

   typedef logic [15:0] q8_8_t;

   // Integer sample -> Q8.8
   function automatic q8_8_t to_q8_8(input logic [7:0] p);
      return {p, 8'h00};
   endfunction

   // a + (((b - a) * f) >>> 8); the arithmetic shift floors negative steps,
   // and because f < 1 the result stays between a and b.
   function automatic q8_8_t lerp(input q8_8_t a, input q8_8_t b, input logic [7:0] f);
      logic signed [16:0] diff;
      logic signed [24:0] prod;
      diff = $signed({1'b0, b}) - $signed({1'b0, a});
      prod = 25'(diff) * 25'($signed({1'b0, f}));
      return q8_8_t'(25'($signed({1'b0, a})) + (prod >>> 8));
   endfunction

   // Q8.8 -> 8-bit integer, truncating. The integer part already spans the
   // full 8-bit range, so the clamp can never be exceeded.
   function automatic logic [7:0] from_q8_8_sat(input q8_8_t q);
      return 8'(q >> 8);
   endfunction

   // Clamp an unsigned value to [0, 2^w-1].
   function automatic logic [63:0] sat_unsigned(input logic [63:0] v, input int w);
      logic [63:0] lim;
      lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/interp_lerp_q.sv
// ---------------------------------------------------------------------------
// interp_lerp_q
// Combinational single linear interpolation in Q(PIX_W).(FRAC_W):
//   o_y = i_a + (((i_b - i_a) * i_f) >>> FRAC_W)
// Ports:
//   i_a, i_b : endpoints, unsigned fixed point, PIX_W+FRAC_W bits
//   i_f      : fraction f/2^FRAC_W, unsigned, FRAC_W bits
//   o_y      : result, unsigned fixed point, PIX_W+FRAC_W bits
// ---------------------------------------------------------------------------
module interp_lerp_q #(
   parameter int PIX_W  = 8,
   parameter int FRAC_W = 8
) (
   input  logic [PIX_W+FRAC_W-1:0] i_a,
   input  logic [PIX_W+FRAC_W-1:0] i_b,
   input  logic [FRAC_W-1:0]       i_f,
   output logic [PIX_W+FRAC_W-1:0] o_y
);

   localparam int QW = PIX_W + FRAC_W;          // fixed-point sample width
   localparam int PW = PIX_W + 2*FRAC_W + 1;    // signed product width

   localparam logic        [QW-1:0] Y_MAX = '1;
   localparam logic signed [PW-1:0] Q_MAX = $signed(PW'(Y_MAX));

   logic signed [QW:0]     w_diff;
   logic signed [FRAC_W:0] w_f;
   logic signed [PW-1:0]   w_prod;
   logic signed [PW-1:0]   w_sh;
   logic signed [PW-1:0]   w_sum;

   assign w_diff = $signed({1'b0, i_b}) - $signed({1'b0, i_a});
   assign w_f    = $signed({1'b0, i_f});
   assign w_prod = PW'(w_diff) * PW'(w_f);
   // Arithmetic shift floors toward -inf, so falling gradients round down too.
   assign w_sh   = w_prod >>> FRAC_W;
   assign w_sum  = PW'($signed({1'b0, i_a})) + w_sh;

   // The sum always lies between i_a and i_b; the clamp only narrows the
   // full-width sum back to the sample width without silent wrap.
   assign o_y = w_sum[PW-1]     ? '0    :
                (w_sum > Q_MAX) ? Y_MAX :
                w_sum[QW-1:0];

endmodule

// File: rtl/interp_bilineal_pipe.sv
// ---------------------------------------------------------------------------
// interp_bilineal_pipe
// Three-stage pipelined bilinear interpolator with valid/ready flow control.
//   S1: horizontal lerps i0 = lerp(p00,p10,fx), i1 = lerp(p01,p11,fx), fy, tag
//   S2: vertical lerp out_q = lerp(i0,i1,fy), tag
//   S3: rounded + saturated pixel, out_q, tag
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid / in_ready     : input handshake
//   in_p00/p10/p01/p11      : 2x2 neighbourhood, CH channels of PIX_W bits
//   in_fx / in_fy           : fractions, value f/2^FRAC_W, shared by channels
//   in_tag                  : sideband tag, passed through unchanged
//   out_valid / out_ready   : output handshake
//   out_pixel               : integer pixel, CH*PIX_W
//   out_pixel_q             : fixed-point result before rounding
//   out_tag                 : tag of the beat on out_pixel
//   busy                    : any stage holds a valid beat
//   out_count               : output handshakes since reset, wraps
// ---------------------------------------------------------------------------
module interp_bilineal_pipe
   import formato_pkg::*;
#(
   parameter int PIX_W  = 8,
   parameter int FRAC_W = 8,
   parameter int CH     = 1,
   parameter int ROUND  = ROUND_TRUNC,
   parameter int TAG_W  = 16,
   parameter int CNT_W  = 32
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [CH*PIX_W-1:0]            in_p00,
   input  logic [CH*PIX_W-1:0]            in_p10,
   input  logic [CH*PIX_W-1:0]            in_p01,
   input  logic [CH*PIX_W-1:0]            in_p11,
   input  logic [FRAC_W-1:0]              in_fx,
   input  logic [FRAC_W-1:0]              in_fy,
   input  logic [TAG_W-1:0]               in_tag,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [CH*PIX_W-1:0]            out_pixel,
   output logic [CH*(PIX_W+FRAC_W)-1:0]   out_pixel_q,
   output logic [TAG_W-1:0]               out_tag,
   output logic                           busy,
   output logic [CNT_W-1:0]               out_count
);

   localparam int QW = PIX_W + FRAC_W;

   // Half an LSB of the integer result when rounding to nearest, else 0.
   localparam logic [QW:0] RND_ADD = (ROUND == ROUND_NEAREST) ?
                                     ((QW+1)'(1) << (FRAC_W-1)) : '0;

   // ---------------- stage registers ----------------
   logic                  r_v1, r_v2, r_v3;
   logic [CH*QW-1:0]      r_i0, r_i1;
   logic [FRAC_W-1:0]     r_fy1;
   logic [TAG_W-1:0]      r_tag1, r_tag2, r_tag3;
   logic [CH*QW-1:0]      r_q2, r_q3;
   logic [CH*PIX_W-1:0]   r_pix3;
   logic [CNT_W-1:0]      r_count;

   // ---------------- combinational datapath ----------------
   logic [CH*QW-1:0]      w_i0, w_i1, w_q;
   logic [CH*PIX_W-1:0]   w_pix;
   logic                  w_adv1, w_adv2, w_adv3;

   // Each stage may load when it is empty or its contents move on this
   // cycle; the ready chain is combinational back to in_ready.
   assign w_adv3 = !r_v3 || out_ready;
   assign w_adv2 = !r_v2 || w_adv3;
   assign w_adv1 = !r_v1 || w_adv2;

   for (genvar c = 0; c < CH; c++) begin : g_ch
      logic [QW-1:0] w_a00, w_a10, w_a01, w_a11;
      logic [QW:0]   w_rnd;
      logic [QW:0]   w_int;

      // Samples enter the fixed-point domain as p << FRAC_W.
      assign w_a00 = {in_p00[c*PIX_W +: PIX_W], {FRAC_W{1'b0}}};
      assign w_a10 = {in_p10[c*PIX_W +: PIX_W], {FRAC_W{1'b0}}};
      assign w_a01 = {in_p01[c*PIX_W +: PIX_W], {FRAC_W{1'b0}}};
      assign w_a11 = {in_p11[c*PIX_W +: PIX_W], {FRAC_W{1'b0}}};

      interp_lerp_q #(.PIX_W(PIX_W), .FRAC_W(FRAC_W)) u_lerp_h0 (
         .i_a (w_a00),
         .i_b (w_a10),
         .i_f (in_fx),
         .o_y (w_i0[c*QW +: QW])
      );

      interp_lerp_q #(.PIX_W(PIX_W), .FRAC_W(FRAC_W)) u_lerp_h1 (
         .i_a (w_a01),
         .i_b (w_a11),
         .i_f (in_fx),
         .o_y (w_i1[c*QW +: QW])
      );

      interp_lerp_q #(.PIX_W(PIX_W), .FRAC_W(FRAC_W)) u_lerp_v (
         .i_a (r_i0[c*QW +: QW]),
         .i_b (r_i1[c*QW +: QW]),
         .i_f (r_fy1),
         .o_y (w_q[c*QW +: QW])
      );

      // One extra bit absorbs the rounding carry (e.g. 255.5 -> 256), which
      // the saturation then folds back to the top code.
      assign w_rnd = {1'b0, r_q2[c*QW +: QW]} + RND_ADD;
      assign w_int = w_rnd >> FRAC_W;
      assign w_pix[c*PIX_W +: PIX_W] = PIX_W'(sat_unsigned(64'(w_int), PIX_W));
   end

   // ---------------- pipeline registers ----------------
   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples the previous stage's value from before this clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: data and tag registers are cleared along with the valid
         // bits so no stale beat content is visible after reset.
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_v3    <= 1'b0;
         r_i0    <= '0;
         r_i1    <= '0;
         r_fy1   <= '0;
         r_tag1  <= '0;
         r_q2    <= '0;
         r_tag2  <= '0;
         r_pix3  <= '0;
         r_q3    <= '0;
         r_tag3  <= '0;
         r_count <= '0;
      end else begin
         if (w_adv1) begin
            r_v1   <= in_valid;
            r_i0   <= w_i0;
            r_i1   <= w_i1;
            r_fy1  <= in_fy;
            r_tag1 <= in_tag;
         end
         if (w_adv2) begin
            r_v2   <= r_v1;
            r_q2   <= w_q;
            r_tag2 <= r_tag1;
         end
         if (w_adv3) begin
            r_v3   <= r_v2;
            r_pix3 <= w_pix;
            r_q3   <= r_q2;
            r_tag3 <= r_tag2;
         end
         if (r_v3 && out_ready) begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

   // ---------------- outputs ----------------
   assign in_ready    = w_adv1;
   assign out_valid   = r_v3;
   assign out_pixel   = r_pix3;
   assign out_pixel_q = r_q3;
   assign out_tag     = r_tag3;
   assign busy        = r_v1 || r_v2 || r_v3;
   assign out_count   = r_count;

endmodule
